exc_commit_ctrl: RTL
====================

# exc_commit_ctrl

Exception/interrupt commit controller sitting between the writeback stage and the CP0 register file. Each cycle it takes the exception flags carried by the WB instruction plus the registered interrupt request, and picks one exception by fixed priority. It then drives the CP0 update strobes (`wb_ex`, `wb_excode`, `wb_badvaddr`, `eret_flush`, gated `mtc0_we`) and sequences the pipeline flush and PC redirect through a small state machine.

## Interface
Parameters:
- `EX_VECTOR`, 32'hbfc00380: exception entry PC (BEV=1).
- `FLUSH_CYCLES`, 2: cycles `flush` is held high; range 1..15.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `wb_valid` in 1: WB holds a valid instruction.
- `wb_pc` in 32: PC of the WB instruction.
- `wb_bd` in 1: WB instruction is in a delay slot.
- `wb_data_addr` in 32: load/store effective address.
- `wb_ex_adel_if` in 1: fetch address error.
- `wb_ex_ri` in 1: reserved instruction.
- `wb_ex_ov` in 1: overflow.
- `wb_ex_sys` in 1: syscall.
- `wb_ex_bp` in 1: break.
- `wb_ex_adel_ld` in 1: load address error.
- `wb_ex_ades` in 1: store address error.
- `wb_eret` in 1: WB instruction is ERET.
- `wb_mtc0` in 1: WB instruction is MTC0.
- `has_int` in 1: interrupt request from CP0.
- `c0_epc` in 32: current EPC from CP0.
- `redirect_ready` in 1: fetch accepts the redirect.
- `wb_allowin` out 1: WB may present or commit; equals `state==IDLE`.
- `wb_ex` out 1: exception commit strobe to CP0.
- `wb_excode` out 5: selected ExcCode.
- `wb_badvaddr` out 32: BadVAddr value.
- `eret_flush` out 1: ERET commit strobe to CP0.
- `mtc0_we` out 1: gated MTC0 write enable to CP0.
- `flush` out 1: kill all pipeline stages.
- `redirect_valid` out 1: redirect PC is offered.
- `redirect_pc` out 32: new fetch PC.

## Operation
- `int_q` is a register sampled as `has_int` every cycle; it resets to 0.
- `commit = wb_valid & (state==IDLE)`.
- Priority, highest first:
  - `int_q` → code 0 (INT)
  - `adel_if` → 4
  - `ri` → 10
  - `ov` → 12
  - `sys` → 8
  - `bp` → 9
  - `adel_ld` → 4
  - `ades` → 5
- `any_ex` = commit and any source in the priority list is set.
- `wb_ex = any_ex`, and `wb_excode` is the winning code.
- `wb_excode` is 0 when `wb_ex=0`.
- `wb_badvaddr`:
  - `wb_pc` when the winner is `adel_if`.
  - `wb_data_addr` when the winner is `adel_ld` or `ades`.
  - 0 otherwise.
- `eret_flush = commit & wb_eret & ~any_ex`.
- `mtc0_we = commit & wb_mtc0 & ~any_ex`.
- An exception suppresses ERET and MTC0 commit.
- States: IDLE, FLUSH, REDIRECT.
  - IDLE → FLUSH on `any_ex` or `eret_flush`.
    - Captures `tgt = any_ex ? EX_VECTOR : c0_epc`.
    - Loads counter `cnt = FLUSH_CYCLES-1`.
  - FLUSH: `flush=1`.
    - `cnt` decrements each cycle.
    - At `cnt==0`, go to REDIRECT.
  - REDIRECT: `redirect_valid=1`, `redirect_pc=tgt`.
    - Go to IDLE on `redirect_ready`.
- Outside IDLE, `wb_valid` and all WB flags are ignored. `wb_ex`, `eret_flush` and `mtc0_we` stay 0.
- `int_q` keeps sampling in every state. An interrupt pending at return to IDLE attaches to the first committed instruction.

## Timing
- Reset forces state IDLE, `cnt=0`, `tgt=0`, `int_q=0`.
- Output values during reset:
  - `flush=0`, `redirect_valid=0`, `redirect_pc=0`.
  - `wb_ex=0`, `eret_flush=0`, `mtc0_we=0`.
  - `wb_allowin=1`.
- `wb_ex`, `eret_flush` and `mtc0_we` are combinational. They are single-cycle in the commit cycle T, and CP0 samples them at edge T.
- `flush` is high for cycles T+1 .. T+FLUSH_CYCLES.
- `redirect_valid` rises at T+FLUSH_CYCLES+1.
  - It is held, with `redirect_pc` stable, until sampled together with `redirect_ready`.
  - IDLE resumes the following cycle.
- Minimum exception-to-next-commit: FLUSH_CYCLES+2 cycles.
- `has_int` → `int_q`: 1 cycle latency, so an interrupt asserted in cycle N can tag an instruction committing in N+1 at the earliest.
- `redirect_pc` is `tgt` in REDIRECT and 0 otherwise.
- Reset mid-FLUSH or mid-REDIRECT aborts immediately to IDLE with no redirect.
- Simultaneous ERET and interrupt: the exception wins, `tgt=EX_VECTOR`, and `eret_flush` stays 0.

## Test plan
- **ov commit:** `wb_valid=1`, `wb_ex_ov=1`, `wb_pc=32'h1000` in IDLE → `wb_ex=1`, `wb_excode=12` for 1 cycle; `flush=1` for 2 cycles; `redirect_pc=32'hbfc00380` until `redirect_ready`.
- **Priority/BadVAddr:** `ri=1`, `ades=1`, `wb_data_addr=32'h2003` → code 10, `wb_badvaddr=0`. With `ades` alone → code 5, `wb_badvaddr=32'h2003`. With `adel_if` and `wb_pc=32'h1002` → code 4, `wb_badvaddr=32'h1002`.
- **ERET:** `c0_epc=32'h8000_0040`, `wb_eret=1` → `eret_flush=1`, `wb_ex=0`; after flush, `redirect_pc=32'h8000_0040`. Repeat with `has_int=1` the cycle before → `wb_ex=1`, `wb_excode=0`, `eret_flush=0`, `redirect_pc=EX_VECTOR`.
- **MTC0 gating:** `wb_mtc0` with no exception → `mtc0_we=1`. `wb_mtc0` with `wb_ex_ri` → `mtc0_we=0`. `wb_mtc0` during FLUSH → `mtc0_we=0`.
- **Redirect backpressure:** hold `redirect_ready=0` for 5 cycles → `redirect_valid` and `redirect_pc` stable and `wb_allowin=0`; then ready=1 → IDLE next cycle.
- **Reset abort:** assert `reset` in the 2nd FLUSH cycle → next cycle IDLE, `flush=0`, `redirect_valid=0`, `wb_allowin=1`.

Source files
------------

// File: rtl/exc_commit_ctrl_if.sv
// WB-to-CP0 commit bus: WB instruction and exception flags, CP0 update strobes, and the fetch redirect handshake.
// The master is the pipeline/CP0 side; the slave is the commit controller.
interface exc_commit_ctrl_if;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_bd;
    logic [31:0] wb_data_addr;
    logic        wb_ex_adel_if;
    logic        wb_ex_ri;
    logic        wb_ex_ov;
    logic        wb_ex_sys;
    logic        wb_ex_bp;
    logic        wb_ex_adel_ld;
    logic        wb_ex_ades;
    logic        wb_eret;
    logic        wb_mtc0;
    logic        has_int;
    logic [31:0] c0_epc;
    logic        redirect_ready;

    logic        wb_allowin;
    logic        wb_ex;
    logic [4:0]  wb_excode;
    logic [31:0] wb_badvaddr;
    logic        eret_flush;
    logic        mtc0_we;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output wb_valid, wb_pc, wb_bd, wb_data_addr,
               wb_ex_adel_if, wb_ex_ri, wb_ex_ov, wb_ex_sys, wb_ex_bp,
               wb_ex_adel_ld, wb_ex_ades, wb_eret, wb_mtc0,
               has_int, c0_epc, redirect_ready,
        input  wb_allowin, wb_ex, wb_excode, wb_badvaddr, eret_flush,
               mtc0_we, flush, redirect_valid, redirect_pc
    );

    modport slave (
        input  wb_valid, wb_pc, wb_bd, wb_data_addr,
               wb_ex_adel_if, wb_ex_ri, wb_ex_ov, wb_ex_sys, wb_ex_bp,
               wb_ex_adel_ld, wb_ex_ades, wb_eret, wb_mtc0,
               has_int, c0_epc, redirect_ready,
        output wb_allowin, wb_ex, wb_excode, wb_badvaddr, eret_flush,
               mtc0_we, flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exc_commit_ctrl.sv
// Picks one exception per WB commit by fixed priority, strobes CP0 combinationally in the commit cycle,
// then holds flush for FLUSH_CYCLES and offers the redirect PC until fetch takes it (WB stalled meanwhile).
module exc_commit_ctrl #(
    parameter logic [31:0] EX_VECTOR    = 32'hbfc00380,
    parameter int          FLUSH_CYCLES = 2
) (
    input logic          clk,
    input logic          reset,
    exc_commit_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FLUSH    = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;
    localparam logic [3:0] CNT_INIT   = 4'(FLUSH_CYCLES - 1);

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] tgt;
    logic        int_q;

    logic        idle;
    logic        commit;
    logic        ex_hit;
    logic [4:0]  ex_code;
    logic [31:0] ex_bad;
    logic        any_ex;
    logic        eret_go;

    assign idle   = (state == S_IDLE);
    // Reset gates the commit so no CP0 strobe can escape while the pipeline is being reset.
    assign commit = bus.wb_valid & idle & ~reset;

    always_comb begin
        ex_hit  = 1'b1;
        ex_code = EXC_INT;
        ex_bad  = 32'd0;
        if (int_q) begin
            ex_code = EXC_INT;
        end else if (bus.wb_ex_adel_if) begin
            ex_code = EXC_ADEL;
            ex_bad  = bus.wb_pc;
        end else if (bus.wb_ex_ri) begin
            ex_code = EXC_RI;
        end else if (bus.wb_ex_ov) begin
            ex_code = EXC_OV;
        end else if (bus.wb_ex_sys) begin
            ex_code = EXC_SYS;
        end else if (bus.wb_ex_bp) begin
            ex_code = EXC_BP;
        end else if (bus.wb_ex_adel_ld) begin
            ex_code = EXC_ADEL;
            ex_bad  = bus.wb_data_addr;
        end else if (bus.wb_ex_ades) begin
            ex_code = EXC_ADES;
            ex_bad  = bus.wb_data_addr;
        end else begin
            ex_hit  = 1'b0;
        end
    end

    assign any_ex  = commit & ex_hit;
    assign eret_go = commit & bus.wb_eret & ~any_ex;

    assign bus.wb_ex          = any_ex;
    assign bus.wb_excode      = any_ex ? ex_code : 5'd0;
    assign bus.wb_badvaddr    = any_ex ? ex_bad : 32'd0;
    assign bus.eret_flush     = eret_go;
    assign bus.mtc0_we        = commit & bus.wb_mtc0 & ~any_ex;
    assign bus.wb_allowin     = idle | reset;
    assign bus.flush          = (state == S_FLUSH) & ~reset;
    assign bus.redirect_valid = (state == S_REDIRECT) & ~reset;
    assign bus.redirect_pc    = bus.redirect_valid ? tgt : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            tgt   <= 32'd0;
            int_q <= 1'b0;
        end else begin
            // Sampled in every state so an interrupt raised during a flush tags the first post-redirect commit.
            int_q <= bus.has_int;
            case (state)
                S_IDLE: begin
                    if (any_ex || eret_go) begin
                        state <= S_FLUSH;
                        cnt   <= CNT_INIT;
                        tgt   <= any_ex ? EX_VECTOR : bus.c0_epc;
                    end
                end
                S_FLUSH: begin
                    if (cnt == 4'd0) begin
                        state <= S_REDIRECT;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_REDIRECT: begin
                    if (bus.redirect_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
